crg_jtag_tap: RTL and testbench
===============================

# crg_jtag_tap

IEEE 1149.1-style TAP controller that sits directly upstream of `crg_chip_jtag`. It takes the chip JTAG pins (`tck`, `trstn`, `tms`, `tdi`) and runs the 16-state TAP FSM. It holds the instruction register, the IDCODE register and the BYPASS register, and drives `tdo`/`tdo_en`. It also generates capture/shift/update/mode strobes for the downstream boundary-scan cell chain and returns that chain's serial output on `tdo` when a boundary-scan instruction is selected.

## Interface
- `IR_W`, 4, instruction register width (min 2)
- `IDCODE`, 32'h1000_0C4B, device ID; bit 0 must be 1
- `tck`  in  1  JTAG clock; the only clock; all state changes on rising edge
- `trstn`  in  1  reset; synchronous, active-low (sampled on rising `tck`)
- `tms`  in  1  test mode select
- `tdi`  in  1  serial data in; also feeds the bscan chain head directly
- `bs_tdo`  in  1  serial output of the boundary-scan chain tail
- `tdo`  out  1  serial data out (registered)
- `tdo_en`  out  1  output enable for the `tdo` pad (registered)
- `bs_capture`  out  1  high while in Capture-DR with EXTEST or SAMPLE selected
- `bs_shift`  out  1  high while in Shift-DR with EXTEST or SAMPLE selected
- `bs_update`  out  1  high while in Update-DR with EXTEST or SAMPLE selected
- `bs_mode`  out  1  high while the current instruction is EXTEST
- `ir_out`  out  IR_W  current (updated) instruction
- `tap_state`  out  4  FSM state code, for debug

## Operation
- States, with codes 0-15 in this order: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR.
- Transitions (tms=0 / tms=1):
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - SEL_IR: CAP_IR / TLR
  - CAP_xR: SH_xR / EX1_xR
  - SH_xR: SH_xR / EX1_xR
  - EX1_xR: PAU_xR / UPD_xR
  - PAU_xR: PAU_xR / EX2_xR
  - EX2_xR: SH_xR / UPD_xR
  - UPD_xR: RTI / SEL_DR
- Instructions:
  - EXTEST = all-zeros
  - SAMPLE = 1
  - IDCODE = 2
  - BYPASS = all-ones
  - Any other code behaves as BYPASS.
- IR shift register:
  - CAP_IR loads {0…0,01}.
  - SH_IR shifts right, with `tdi` entering the MSB.
  - UPD_IR copies the shift register into `ir_out`.
- TLR forces `ir_out` to IDCODE every cycle spent in TLR.
- DR selection by `ir_out`:
  - IDCODE: 32-bit register; CAP_DR loads `IDCODE`; SH_DR shifts right with `tdi` into bit 31.
  - BYPASS: 1-bit register; CAP_DR loads 0; SH_DR loads `tdi`.
  - EXTEST/SAMPLE: external chain; serial out is `bs_tdo`.
- Serial output:
  - On each rising edge where the current state is SH_DR/SH_IR, `tdo` takes the LSB of the selected register as it was before that edge's shift.
  - In all other states `tdo` holds its value.
- `tdo_en` is registered as (current state ∈ {SH_DR, SH_IR}). It therefore is high exactly for the cycle after each shift edge.
- `bs_*` strobes are combinational decodes of the current state and `ir_out`.
- Reset (`trstn`=0 at a rising edge) produces:
  - state=TLR, `ir_out`=IDCODE
  - `tdo`=0, `tdo_en`=0
  - IR shift register=0, IDCODE register=`IDCODE`, bypass register=0
  - `bs_mode`=0, all other `bs_*` outputs=0
- Reset overrides `tms` and takes priority mid-shift; a partially shifted IR is discarded with no update.

## Timing
- FSM next state is a function of `tms` sampled on the same rising edge; there is 1-cycle latency from `tms` to `tap_state`.
- From any state, 5 consecutive edges with `tms`=1 reach TLR, regardless of `trstn`.
- IR capture to UPD_IR with N shift cycles: `ir_out` changes on the edge leaving UPD_IR... precisely, on the edge at which the state is UPD_IR. `bs_mode` follows combinationally.
- An instruction change takes effect for DR selection starting from the following SEL_DR.
- BYPASS gives a 1-cycle serial delay: the first `tdo` bit after CAP_DR is 0, then the `tdi` values in order.
- PAU_xR and EX2_xR hold every register unchanged; a shift resumes from EX2→SH without bit loss.

## Test plan
- Reset: hold `trstn`=0 for 2 edges with random `tms`/`tdi` → `tap_state`=0, `ir_out`=4'h2, `tdo`=0, `tdo_en`=0, `bs_mode`=0.
- Soft reset: start from SH_DR, apply `tms`=1 for 5 edges with `trstn`=1 → TLR, `ir_out`=4'h2.
- IDCODE read: after reset go to SH_DR and shift 32 bits → `tdo` sequence LSB-first equals 32'h1000_0C4B; `tdo_en`=1 on each of the 32 cycles.
- IR capture/BYPASS: shift 4'hF via SH_IR → captured bits out on `tdo` are 1,0,0,0. Then in SH_DR shift `tdi`=1,0,1,1 → `tdo`=0,1,0,1.
- EXTEST: load IR 4'h0 → `bs_mode`=1 after UPD_IR. In a DR scan, `bs_capture`, `bs_shift` and `bs_update` each pulse in their states, and `tdo` tracks `bs_tdo` one edge late. Loading 4'h5 then behaves as BYPASS.
- Reset mid-IR-shift: while in SH_IR after 2 bits, assert `trstn`=0 → next edge gives TLR and `ir_out`=4'h2 with no partial update. Pause/resume of a 32-bit IDCODE shift via PAU_DR/EX2_DR still yields the exact IDCODE.

Source files
------------

// File: rtl/crg_jtag_tap.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, IR, IDCODE and BYPASS
// registers, plus strobes for an external boundary-scan cell chain.
module crg_jtag_tap #(
  parameter int          IR_W   = 4,
  parameter logic [31:0] IDCODE = 32'h1000_0C4B
) (
  input  logic            tck,
  input  logic            trstn,
  input  logic            tms,
  input  logic            tdi,
  input  logic            bs_tdo,
  output logic            tdo,
  output logic            tdo_en,
  output logic            bs_capture,
  output logic            bs_shift,
  output logic            bs_update,
  output logic            bs_mode,
  output logic [IR_W-1:0] ir_out,
  output logic [3:0]      tap_state
);

  localparam logic [IR_W-1:0] I_EXTEST = '0;
  localparam logic [IR_W-1:0] I_SAMPLE = IR_W'(1);
  localparam logic [IR_W-1:0] I_IDCODE = IR_W'(2);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } state_t;

  state_t          r_state, w_next;
  logic [IR_W-1:0] r_ir, r_ir_sr;
  logic [31:0]     r_id;
  logic            r_byp, r_tdo, r_tdo_en;
  logic            w_sel_bs, w_sel_id, w_dr_lsb;

  // Next-state decode from tms
  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:    w_next = tms ? TLR    : RTI;
      RTI:    w_next = tms ? SEL_DR : RTI;
      SEL_DR: w_next = tms ? SEL_IR : CAP_DR;
      CAP_DR: w_next = tms ? EX1_DR : SH_DR;
      SH_DR:  w_next = tms ? EX1_DR : SH_DR;
      EX1_DR: w_next = tms ? UPD_DR : PAU_DR;
      PAU_DR: w_next = tms ? EX2_DR : PAU_DR;
      EX2_DR: w_next = tms ? UPD_DR : SH_DR;
      UPD_DR: w_next = tms ? SEL_DR : RTI;
      SEL_IR: w_next = tms ? TLR    : CAP_IR;
      CAP_IR: w_next = tms ? EX1_IR : SH_IR;
      SH_IR:  w_next = tms ? EX1_IR : SH_IR;
      EX1_IR: w_next = tms ? UPD_IR : PAU_IR;
      PAU_IR: w_next = tms ? EX2_IR : PAU_IR;
      EX2_IR: w_next = tms ? UPD_IR : SH_IR;
      UPD_IR: w_next = tms ? SEL_DR : RTI;
      default: w_next = TLR;
    endcase
  end

  // State register; trstn overrides tms
  always_ff @(posedge tck) begin
    if (!trstn) r_state <= TLR;
    else        r_state <= w_next;
  end

  // Instruction decode; codes other than EXTEST/SAMPLE/IDCODE select bypass
  assign w_sel_bs = (r_ir == I_EXTEST) || (r_ir == I_SAMPLE);
  assign w_sel_id = (r_ir == I_IDCODE);
  assign w_dr_lsb = w_sel_id ? r_id[0] : (w_sel_bs ? bs_tdo : r_byp);

  // IR shift stage and update latch; IDCODE is loaded on every edge landing
  // in TLR so ir_out reads IDCODE for every cycle spent there
  always_ff @(posedge tck) begin
    if (!trstn) begin
      r_ir_sr <= '0;
      r_ir    <= I_IDCODE;
    end else begin
      if (r_state == CAP_IR)     r_ir_sr <= IR_W'(1);
      else if (r_state == SH_IR) r_ir_sr <= {tdi, r_ir_sr[IR_W-1:1]};
      if (r_state == UPD_IR)     r_ir <= r_ir_sr;
      else if (w_next == TLR)    r_ir <= I_IDCODE;
    end
  end

  // IDCODE and BYPASS data registers; only the selected one moves
  always_ff @(posedge tck) begin
    if (!trstn) begin
      r_id  <= IDCODE;
      r_byp <= 1'b0;
    end else if (r_state == CAP_DR) begin
      if (w_sel_id)       r_id  <= IDCODE;
      else if (!w_sel_bs) r_byp <= 1'b0;
    end else if (r_state == SH_DR) begin
      if (w_sel_id)       r_id  <= {tdi, r_id[31:1]};
      else if (!w_sel_bs) r_byp <= tdi;
    end
  end

  // tdo takes the pre-shift LSB on shift edges and holds otherwise
  always_ff @(posedge tck) begin
    if (!trstn) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      if (r_state == SH_DR)      r_tdo <= w_dr_lsb;
      else if (r_state == SH_IR) r_tdo <= r_ir_sr[0];
      r_tdo_en <= (r_state == SH_DR) || (r_state == SH_IR);
    end
  end

  assign tdo        = r_tdo;
  assign tdo_en     = r_tdo_en;
  assign ir_out     = r_ir;
  assign tap_state  = r_state;
  assign bs_mode    = (r_ir == I_EXTEST);
  assign bs_capture = w_sel_bs && (r_state == CAP_DR);
  assign bs_shift   = w_sel_bs && (r_state == SH_DR);
  assign bs_update  = w_sel_bs && (r_state == UPD_DR);

endmodule

// File: tb/tb_crg_jtag_tap.sv
// Randomized self-checking bench for crg_jtag_tap against a table-driven model.
module tb_crg_jtag_tap;
  localparam logic [31:0] ID = 32'h1000_0C4B;

  logic tck = 1'b0, trstn = 1'b0, tms = 1'b0, tdi = 1'b0, bs_tdo = 1'b0;
  logic tdo, tdo_en, bs_capture, bs_shift, bs_update, bs_mode;
  logic [3:0] ir_out, tap_state;
  int checks = 0, failures = 0;
  logic last_bs;

  crg_jtag_tap #(.IR_W(4), .IDCODE(ID)) dut (
    .tck(tck), .trstn(trstn), .tms(tms), .tdi(tdi), .bs_tdo(bs_tdo),
    .tdo(tdo), .tdo_en(tdo_en), .bs_capture(bs_capture), .bs_shift(bs_shift),
    .bs_update(bs_update), .bs_mode(bs_mode), .ir_out(ir_out), .tap_state(tap_state)
  );

  always #5 tck = ~tck;

  // Reference model: transition tables indexed by state code
  int NXT0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int NXT1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int m_state;
  logic [3:0] m_ir, m_irsr;
  logic [31:0] m_id;
  logic m_byp, m_tdo, m_en;

  task automatic model_edge();
    int nxt;
    logic id_sel, bs_sel;
    nxt = tms ? NXT1[m_state] : NXT0[m_state];
    if (!trstn) begin
      m_state = 0; m_ir = 4'h2; m_irsr = 4'h0; m_id = ID; m_byp = 1'b0;
      m_tdo = 1'b0; m_en = 1'b0;
    end else begin
      id_sel = (m_ir == 4'h2);
      bs_sel = (m_ir <= 4'h1);
      if (m_state == 3) begin
        if (id_sel) m_id = ID; else if (!bs_sel) m_byp = 1'b0;
      end
      if (m_state == 4) begin
        m_tdo = id_sel ? m_id[0] : (bs_sel ? bs_tdo : m_byp);
        if (id_sel) m_id = {tdi, m_id[31:1]};
        else if (!bs_sel) m_byp = tdi;
      end
      if (m_state == 10) m_irsr = 4'h1;
      if (m_state == 11) begin
        m_tdo = m_irsr[0];
        m_irsr = {tdi, m_irsr[3:1]};
      end
      if (m_state == 15) m_ir = m_irsr;
      else if (nxt == 0) m_ir = 4'h2;
      m_en = (m_state == 4) || (m_state == 11);
      m_state = nxt;
    end
  endtask

  // One TCK cycle: drive, advance model, sample 1ns after the rising edge
  task automatic tick(input logic t, input logic d);
    tms = t; tdi = d; bs_tdo = 1'($urandom); last_bs = bs_tdo;
    model_edge();
    @(posedge tck); #1;
  endtask

  task automatic to_rti();
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI: load an IR value, return the captured bits LSB-first, end in RTI
  task automatic shift_ir(input logic [3:0] v, output logic [3:0] cap);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, v[i]);
      cap[i] = tdo;
    end
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
  endtask

  // From RTI: n-bit DR scan, tdo collected LSB-first, end in RTI
  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i]);
      dout[i] = tdo;
    end
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    trstn = 1'b0;
    repeat (2) tick(1'($urandom), 1'($urandom));
    checks++;
    if ({tap_state, ir_out, tdo, tdo_en, bs_mode, bs_capture, bs_shift, bs_update} !== {4'h0, 4'h2, 6'b0}) begin
      failures++;
      $display("FAIL reset: state=%0d ir=%h tdo=%b en=%b bs=%b%b%b%b expected 0/2/0/0/0000",
               tap_state, ir_out, tdo, tdo_en, bs_mode, bs_capture, bs_shift, bs_update);
    end
    trstn = 1'b1;
  endtask

  task automatic test_idcode();
    logic [31:0] got;
    logic en_ok = 1'b1;
    tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      tick(i == 31, 1'($urandom));
      got[i] = tdo;
      if (tdo_en !== 1'b1) en_ok = 1'b0;
    end
    checks++;
    if (got !== ID) begin failures++; $display("FAIL idcode_read: got %h expected %h", got, ID); end
    checks++;
    if (!en_ok) begin failures++; $display("FAIL idcode_tdo_en: low during shift, expected 1"); end
    tick(1'b1, 1'b0);
    checks++;
    if (tdo_en !== 1'b0) begin failures++; $display("FAIL tdo_en_after: got %b expected 0", tdo_en); end
    tick(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'd1) begin failures++; $display("FAIL idcode_to_rti: state=%0d expected 1", tap_state); end
  endtask

  task automatic test_ir_bypass();
    logic [3:0] cap;
    logic [31:0] d, o;
    shift_ir(4'hF, cap);
    checks++;
    if (cap !== 4'b0001 || ir_out !== 4'hF) begin
      failures++; $display("FAIL ir_capture: cap=%b ir=%h expected 0001/f", cap, ir_out);
    end
    scan_dr(4, 32'b1101, o);
    checks++;
    if (o[3:0] !== 4'b1010) begin failures++; $display("FAIL bypass_fixed: got %b expected 1010", o[3:0]); end
    d = $urandom;
    scan_dr(12, d, o);
    checks++;
    if (o[11:0] !== {d[10:0], 1'b0}) begin
      failures++; $display("FAIL bypass_rand: got %h expected %h", o[11:0], {d[10:0], 1'b0});
    end
  endtask

  task automatic test_extest();
    logic [3:0] cap;
    logic [31:0] o;
    logic trk = 1'b1;
    shift_ir(4'h0, cap);
    checks++;
    if (bs_mode !== 1'b1 || ir_out !== 4'h0) begin
      failures++; $display("FAIL extest_mode: bs_mode=%b ir=%h expected 1/0", bs_mode, ir_out);
    end
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    checks++;
    if ({bs_capture, bs_shift, bs_update} !== 3'b100) begin
      failures++; $display("FAIL bs_capture: got %b expected 100", {bs_capture, bs_shift, bs_update});
    end
    tick(1'b0, 1'b0);
    checks++;
    if ({bs_capture, bs_shift, bs_update} !== 3'b010) begin
      failures++; $display("FAIL bs_shift: got %b expected 010", {bs_capture, bs_shift, bs_update});
    end
    for (int i = 0; i < 6; i++) begin
      tick(i == 5, 1'($urandom));
      if (tdo !== last_bs) trk = 1'b0;
    end
    checks++;
    if (!trk) begin failures++; $display("FAIL extest_tdo: tdo did not follow bs_tdo, expected tracking"); end
    tick(1'b1, 1'b0);
    checks++;
    if ({bs_capture, bs_shift, bs_update} !== 3'b001) begin
      failures++; $display("FAIL bs_update: got %b expected 001", {bs_capture, bs_shift, bs_update});
    end
    tick(1'b0, 1'b0);
    shift_ir(4'h1, cap);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    checks++;
    if (bs_mode !== 1'b0 || bs_capture !== 1'b1) begin
      failures++; $display("FAIL sample: bs_mode=%b bs_capture=%b expected 0/1", bs_mode, bs_capture);
    end
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    shift_ir(4'h5, cap);
    scan_dr(4, 32'b0110, o);
    checks++;
    if (bs_mode !== 1'b0 || o[3:0] !== 4'b1100) begin
      failures++; $display("FAIL unknown_as_bypass: bs_mode=%b out=%b expected 0/1100", bs_mode, o[3:0]);
    end
  endtask

  task automatic test_soft_reset();
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'd4) begin failures++; $display("FAIL soft_reset_entry: state=%0d expected 4", tap_state); end
    repeat (5) tick(1'b1, 1'($urandom));
    checks++;
    if (tap_state !== 4'd0 || ir_out !== 4'h2) begin
      failures++; $display("FAIL soft_reset: state=%0d ir=%h expected 0/2", tap_state, ir_out);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_ir();
    logic [3:0] cap;
    shift_ir(4'h0, cap);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    trstn = 1'b0;
    tick(1'b1, 1'b1);
    checks++;
    if (tap_state !== 4'd0 || ir_out !== 4'h2 || tdo_en !== 1'b0) begin
      failures++; $display("FAIL reset_mid_ir: state=%0d ir=%h en=%b expected 0/2/0", tap_state, ir_out, tdo_en);
    end
    trstn = 1'b1;
    tick(1'b0, 1'b0);
  endtask

  task automatic test_pause_resume();
    logic [31:0] got;
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      logic p;
      p = (i != 31) && ($urandom_range(0, 3) == 0);
      tick(p || i == 31, 1'($urandom));
      got[i] = tdo;
      if (p) begin
        tick(1'b0, 1'b0);
        repeat ($urandom_range(0, 3)) tick(1'b0, 1'($urandom));
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
      end
    end
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    checks++;
    if (got !== ID) begin failures++; $display("FAIL pause_resume: got %h expected %h", got, ID); end
  endtask

  task automatic test_random_walk();
    logic [13:0] act, exp;
    logic bsel;
    for (int n = 0; n < 400; n++) begin
      trstn = ($urandom_range(0, 59) != 0);
      tick($urandom_range(0, 9) < 4, 1'($urandom));
      bsel = (m_ir <= 4'h1);
      act = {tap_state, ir_out, tdo, tdo_en, bs_mode, bs_capture, bs_shift, bs_update};
      exp = {4'(m_state), m_ir, m_tdo, m_en, m_ir == 4'h0,
             bsel && m_state == 3, bsel && m_state == 4, bsel && m_state == 8};
      checks++;
      if (act !== exp) begin
        failures++; $display("FAIL random_walk[%0d]: got %b expected %b", n, act, exp);
      end
    end
    trstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_idcode();
    to_rti();
    test_ir_bypass();
    test_extest();
    test_soft_reset();
    test_reset_mid_ir();
    to_rti();
    test_pause_resume();
    test_random_walk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
